// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver / consumer side and the receive FIFO.
// The slave modport is the FIFO's view; master is the view of whatever drives it.
interface uart_rx_fifo_if #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
);
  logic                  i_wr_valid;
  logic [DATA_W-1:0]     i_wr_data;
  logic                  i_rd_en;
  logic                  i_flush;
  logic                  i_clr_ovf;
  logic [DATA_W-1:0]     o_rd_data;
  logic                  o_rd_valid;
  logic                  o_empty;
  logic                  o_full;
  logic [DEPTH_LOG2:0]   o_count;
  logic                  o_overflow;
  logic                  o_afull;
  logic                  o_aempty;

  modport master (
    output i_wr_valid, i_wr_data, i_rd_en, i_flush, i_clr_ovf,
    input  o_rd_data, o_rd_valid, o_empty, o_full, o_count, o_overflow, o_afull, o_aempty
  );

  modport slave (
    input  i_wr_valid, i_wr_data, i_rd_en, i_flush, i_clr_ovf,
    output o_rd_data, o_rd_valid, o_empty, o_full, o_count, o_overflow, o_afull, o_aempty
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: registered read port, status flags, sticky overflow.
// Define UART_RX_FIFO_THRESH_EN to get registered almost-full / almost-empty flags.
module uart_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  uart_rx_fifo_if.slave   bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [DATA_W-1:0]     mem [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
  logic [DEPTH_LOG2:0]   count_reg, count_next;
  logic                  empty_reg, full_reg;
  logic                  overflow_reg, overflow_next;
  logic                  rd_valid_reg, rd_valid_next;
  logic [DATA_W-1:0]     rd_data_reg;

  logic                  rd_accept;
  logic                  wr_accept;
  logic                  wr_drop;

  // Flush wins over both ports; a full FIFO still takes a write when a read frees the slot.
  always_comb begin
    rd_accept = bus.i_rd_en && !empty_reg && !bus.i_flush;
    wr_accept = bus.i_wr_valid && (!full_reg || rd_accept) && !bus.i_flush;
    wr_drop   = bus.i_wr_valid && full_reg && !rd_accept && !bus.i_flush;
  end

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    rd_valid_next = rd_accept;
    overflow_next = overflow_reg;

    if (bus.i_flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      case ({wr_accept, rd_accept})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end

    // A fresh drop beats a simultaneous clear.
    if (wr_drop) begin
      overflow_next = 1'b1;
    end else if (bus.i_clr_ovf) begin
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      empty_reg    <= 1'b1;
      full_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      empty_reg    <= (count_next == '0);
      full_reg     <= (count_next == DEPTH_CNT);
      overflow_reg <= overflow_next;
      rd_valid_reg <= rd_valid_next;
    end
  end

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (wr_accept) begin
      mem[wr_ptr_reg] <= bus.i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rd_data_reg <= '0;
    end else if (rd_accept) begin
      rd_data_reg <= mem[rd_ptr_reg];
    end
  end

`ifdef UART_RX_FIFO_THRESH_EN
  logic afull_reg, aempty_reg;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      afull_reg  <= 1'b0;
      aempty_reg <= 1'b1;
    end else begin
      afull_reg  <= (int'(count_next) >= AFULL_LVL);
      aempty_reg <= (int'(count_next) <= AEMPTY_LVL);
    end
  end

  assign bus.o_afull  = afull_reg;
  assign bus.o_aempty = aempty_reg;
`else
  logic unused_thresh;
  assign unused_thresh = (AFULL_LVL > AEMPTY_LVL);
  assign bus.o_afull   = 1'b0;
  assign bus.o_aempty  = 1'b1;
`endif

  assign bus.o_rd_data  = rd_data_reg;
  assign bus.o_rd_valid = rd_valid_reg;
  assign bus.o_empty    = empty_reg;
  assign bus.o_full     = full_reg;
  assign bus.o_count    = count_reg;
  assign bus.o_overflow = overflow_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a queue-based model tracks contents, a negedge monitor checks outputs.
// Threshold checks follow UART_RX_FIFO_THRESH_EN when the bench is built with it.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  uart_rx_fifo_if #(.DATA_W(8), .DEPTH_LOG2(4)) bus ();

  uart_rx_fifo #(
    .DATA_W(8), .DEPTH_LOG2(4), .AFULL_LVL(12), .AEMPTY_LVL(2)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: stored bytes, expected read-port state, sticky flag.
  logic [7:0] model_q[$];
  logic [7:0] sb_q[$];
  bit         exp_valid = 1'b0;
  logic [7:0] exp_rd_data = 8'h00;
  bit         exp_ovf = 1'b0;
  logic [7:0] last_rd = 8'h00;
  int         rd_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model is advanced right after the edge it describes.
  task automatic cycle(input bit wr, input logic [7:0] d, input bit rd,
                       input bit fl = 1'b0, input bit clr = 1'b0);
    bit rd_acc, wr_acc, drop;
    bus.i_wr_valid = wr;
    bus.i_wr_data  = d;
    bus.i_rd_en    = rd;
    bus.i_flush    = fl;
    bus.i_clr_ovf  = clr;
    @(posedge clk);
    #1;
    rd_acc = rd && (model_q.size() > 0) && !fl;
    wr_acc = wr && ((model_q.size() < DEPTH) || rd_acc) && !fl;
    drop   = wr && (model_q.size() == DEPTH) && !rd_acc && !fl;
    exp_valid = rd_acc;
    if (fl) begin
      model_q.delete();
    end else begin
      if (rd_acc) begin
        exp_rd_data = model_q.pop_front();
        sb_q.push_back(exp_rd_data);
      end
      if (wr_acc) model_q.push_back(d);
    end
    if (drop) exp_ovf = 1'b1;
    else if (clr) exp_ovf = 1'b0;
    bus.i_wr_valid = 1'b0;
    bus.i_rd_en    = 1'b0;
    bus.i_flush    = 1'b0;
    bus.i_clr_ovf  = 1'b0;
  endtask

  always @(negedge clk) begin
    check("count", 32'(bus.o_count), model_q.size());
    check("empty", 32'(bus.o_empty), 32'(model_q.size() == 0));
    check("full", 32'(bus.o_full), 32'(model_q.size() == DEPTH));
    check("overflow", 32'(bus.o_overflow), 32'(exp_ovf));
    check("rd_valid", 32'(bus.o_rd_valid), 32'(exp_valid));
    check("rd_data_hold", 32'(bus.o_rd_data), 32'(exp_rd_data));
`ifdef UART_RX_FIFO_THRESH_EN
    check("afull", 32'(bus.o_afull), 32'(model_q.size() >= 12));
    check("aempty", 32'(bus.o_aempty), 32'(model_q.size() <= 2));
`else
    check("afull_tied", 32'(bus.o_afull), 32'd0);
    check("aempty_tied", 32'(bus.o_aempty), 32'd1);
`endif
    if (bus.o_rd_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL rd_unexpected: got %02h, expected no read at %0t", bus.o_rd_data, $time);
      end else begin
        logic [7:0] e;
        e = sb_q.pop_front();
        $display("[TB] rd %02h expected %02h", bus.o_rd_data, e);
        check("rd_data", 32'(bus.o_rd_data), 32'(e));
        last_rd = bus.o_rd_data;
        rd_seen++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_wr_valid = 1'b0;
    bus.i_wr_data  = 8'h00;
    bus.i_rd_en    = 1'b0;
    bus.i_flush    = 1'b0;
    bus.i_clr_ovf  = 1'b0;

    // 1: reset state, then reads on an empty FIFO
    repeat (2) @(posedge clk);
    #1;
    check("reset_count", 32'(bus.o_count), 32'd0);
    check("reset_empty", 32'(bus.o_empty), 32'd1);
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    check("empty_reads", 32'(rd_seen), 32'd0);

    // 2: three bytes through
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b1, 8'hFF, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    check("t2_last", 32'(last_rd), 32'hFF);

    // 3: fill, drop, drain, clear overflow
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0);
    check("t3_full", 32'(bus.o_full), 32'd1);
    cycle(1'b1, 8'h55, 1'b0);
    check("t3_ovf", 32'(bus.o_overflow), 32'd1);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("t3_last", 32'(last_rd), 32'h0F);
    check("t3_ovf_clr", 32'(bus.o_overflow), 32'd0);

    // 4: write and read together while full
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
    cycle(1'b1, 8'h77, 1'b1);
    check("t4_count", 32'(bus.o_count), 32'd16);
    check("t4_ovf", 32'(bus.o_overflow), 32'd0);
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    check("t4_last", 32'(last_rd), 32'h77);

    // 5: interleaved traffic across the wrap, then flush
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h80 + i), i >= 3);
    repeat (3) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    check("t5_last", 32'(last_rd), 32'h93);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("t5_flush_count", 32'(bus.o_count), 32'd0);

    // 6: asynchronous reset with 8 entries stored
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'hE0 + i), 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_async_count", 32'(bus.o_count), 32'd0);
    check("t6_async_empty", 32'(bus.o_empty), 32'd1);
    model_q.delete();
    sb_q.delete();
    exp_valid   = 1'b0;
    exp_rd_data = 8'h00;
    exp_ovf     = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      bit fl, wr, rd, clr;
      fl  = ($urandom_range(99) == 0);
      wr  = !fl && ($urandom_range(99) < 60);
      rd  = ($urandom_range(99) < 50);
      clr = !fl && ($urandom_range(49) == 0);
      cycle(wr, 8'($urandom), rd, fl, clr);
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    check("final_sb_drained", 32'(sb_q.size()), 32'd0);
    check("final_empty", 32'(bus.o_empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
